afifo_rd_drain: RTL and testbench

Read-side consumer for the async FIFO. Drives pop from the FIFO's empty flag and takes the 1-cycle-latency vld/data_out return. Lands words in a small local buffer and presents them downstream as a valid/ready stream. Sits in the rclk domain, between the FIFO read port and any backpressuring sink.

---
 rtl/afifo_pkg.sv | 11 +
 rtl/afifo_rd_drain_if.sv | 31 +++
 rtl/afifo_rd_buf.sv | 73 +++++++
 rtl/afifo_rd_drain.sv | 76 +++++++
 tb/tb_afifo_rd_drain.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO read-side drain: error bit
// positions and the sticky error vector type.
package afifo_pkg;

  localparam int ERR_OVF  = 0;
  localparam int ERR_SPUR = 1;
  localparam int ERR_W    = 2;

  typedef logic [ERR_W-1:0] err_t;

endpackage

// File: rtl/afifo_rd_drain_if.sv
// Bundle of the FIFO read port and the downstream valid/ready stream
// seen by the read-side drain. master = the drain, slave = its environment.
interface afifo_rd_drain_if
  import afifo_pkg::*;
#(
  parameter int DW    = 24,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) ();

  logic          fifo_empty;
  logic          fifo_pop;
  logic          fifo_vld;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] occupancy;
  err_t          err;

  modport master (
    input  fifo_empty, fifo_vld, fifo_data, m_ready,
    output fifo_pop, m_valid, m_data, occupancy, err
  );

  modport slave (
    output fifo_empty, fifo_vld, fifo_data, m_ready,
    input  fifo_pop, m_valid, m_data, occupancy, err
  );

endinterface

// File: rtl/afifo_rd_buf.sv
// Small circular landing buffer for words returned by the FIFO. DEPTH need
// not be a power of two, so pointers wrap on an explicit compare.
module afifo_rd_buf
  import afifo_pkg::*;
#(
  parameter int DW    = 24,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign rd_valid  = (count != '0);
  assign do_wr     = wr_en && !full;
  assign do_rd     = rd_valid && rd_ready;
  assign rd_data   = mem[rd_ptr];
  assign occupancy = count;

  // Storage array; cleared on reset so the output word reads zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous write and read leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/afifo_rd_drain.sv
// Read-side consumer for the async FIFO: issues pops against the empty flag,
// tracks the one word in flight, lands returns in a local buffer and
// presents them downstream as a valid/ready stream. Protocol errors are sticky.
module afifo_rd_drain
  import afifo_pkg::*;
#(
  parameter int DW    = 24,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             rst_n,
  afifo_rd_drain_if.master bus
);

  logic          inflight;
  err_t          err_q;
  logic          buf_full;
  logic          buf_valid;
  logic [DW-1:0] buf_data;
  logic [CW-1:0] buf_occ;
  logic [CW:0]   demand;
  logic          pop;

  afifo_rd_buf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (bus.fifo_vld),
    .wr_data   (bus.fifo_data),
    .full      (buf_full),
    .rd_valid  (buf_valid),
    .rd_ready  (bus.m_ready),
    .rd_data   (buf_data),
    .occupancy (buf_occ)
  );

  // Pop only when the word would have a guaranteed slot; held low while in reset.
  always_comb begin
    demand = {1'b0, buf_occ} + {{CW{1'b0}}, inflight};
    pop    = rst_n && !bus.fifo_empty && (demand < (CW+1)'(DEPTH));
  end

  // One-bit tracker for the word due on fifo_vld in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= pop;
    end
  end

  // Sticky protocol errors: return into a full buffer, or a return with no pop behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      if (bus.fifo_vld && buf_full) begin
        err_q[ERR_OVF] <= 1'b1;
      end
      if (bus.fifo_vld && !inflight) begin
        err_q[ERR_SPUR] <= 1'b1;
      end
    end
  end

  assign bus.fifo_pop  = pop;
  assign bus.m_valid   = buf_valid;
  assign bus.m_data    = buf_data;
  assign bus.occupancy = buf_occ;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Bench for afifo_rd_drain: a FIFO read-port model with 1-cycle return
// latency feeds the drain; returned words go to a scoreboard and are matched
// against the downstream stream. Extra DEPTH=2/3 instances measure throughput.
module tb_afifo_rd_drain;
  import afifo_pkg::*;

  localparam int DW    = 24;
  localparam int DEPTH = 4;

  typedef struct {
    logic empty;
    logic ready;
    logic exp_pop;
    int   exp_occ;
    logic exp_valid;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  afifo_rd_drain_if #(.DW(DW), .DEPTH(DEPTH)) bus ();
  afifo_rd_drain_if #(.DW(DW), .DEPTH(2))     bus2 ();
  afifo_rd_drain_if #(.DW(DW), .DEPTH(3))     bus3 ();

  afifo_rd_drain #(.DW(DW), .DEPTH(DEPTH)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  afifo_rd_drain #(.DW(DW), .DEPTH(2))     dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  afifo_rd_drain #(.DW(DW), .DEPTH(3))     dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] sb[$];
  logic          pend_vld   = 1'b0;
  logic [DW-1:0] pend_data  = '0;
  logic          inflight_m = 1'b0;
  logic [DW-1:0] next_word  = 24'd1;
  logic [DW-1:0] next_force = 24'hA00000;
  err_t          exp_err    = '0;

  logic          meas_on = 1'b0;
  int            beats2  = 0;
  int            beats3  = 0;
  logic          pend2   = 1'b0;
  logic          pend3   = 1'b0;
  logic [DW-1:0] word2   = '0;
  logic [DW-1:0] word3   = '0;

  // Throughput instances: FIFO never empty, sink always ready.
  initial begin
    bus2.fifo_empty = 1'b0; bus2.m_ready = 1'b1; bus2.fifo_vld = 1'b0; bus2.fifo_data = '0;
    bus3.fifo_empty = 1'b0; bus3.m_ready = 1'b1; bus3.fifo_vld = 1'b0; bus3.fifo_data = '0;
  end

  // FIFO return model and beat counter for the DEPTH=2 instance.
  always @(negedge clk) begin
    bus2.fifo_vld  = pend2;
    bus2.fifo_data = word2;
    #1;
    if (meas_on && bus2.m_valid && bus2.m_ready) beats2++;
    pend2 = bus2.fifo_pop;
    if (bus2.fifo_pop) word2 = word2 + 1'b1;
  end

  // FIFO return model and beat counter for the DEPTH=3 instance.
  always @(negedge clk) begin
    bus3.fifo_vld  = pend3;
    bus3.fifo_data = word3;
    #1;
    if (meas_on && bus3.m_valid && bus3.m_ready) beats3++;
    pend3 = bus3.fifo_pop;
    if (bus3.fifo_pop) word3 = word3 + 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One cycle: drive inputs at the falling edge, then check and update the model.
  task automatic applyStimulus(input logic empty_in, input logic ready_in, input logic force_vld);
    logic          vld;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_word;
    int            occ_now;
    @(negedge clk);
    vld = pend_vld || force_vld;
    if (pend_vld) begin
      data = pend_data;
    end else begin
      data = next_force;
      if (force_vld) next_force = next_force + 1'b1;
    end
    bus.fifo_empty = empty_in;
    bus.m_ready    = ready_in;
    bus.fifo_vld   = vld;
    bus.fifo_data  = data;
    #1;
    occ_now = sb.size();
    checkOutput("occupancy", 32'(bus.occupancy), 32'(occ_now));
    checkOutput("m_valid", 32'(bus.m_valid), 32'(occ_now != 0));
    checkOutput("err", 32'(bus.err), 32'(exp_err));
    checkOutput("fifo_pop", 32'(bus.fifo_pop), 32'(!empty_in && ((occ_now + int'(inflight_m)) < DEPTH)));
    if (empty_in) checkOutput("no_pop_when_empty", 32'(bus.fifo_pop), 32'd0);
    if (bus.m_valid && ready_in && sb.size() > 0) begin
      exp_word = sb.pop_front();
      checkOutput("m_data", 32'(bus.m_data), 32'(exp_word));
    end
    if (vld) begin
      if (!inflight_m) exp_err[ERR_SPUR] = 1'b1;
      if (occ_now >= DEPTH) exp_err[ERR_OVF] = 1'b1;
      else sb.push_back(data);
    end
    inflight_m = bus.fifo_pop;
    pend_vld   = bus.fifo_pop && !empty_in;
    if (pend_vld) begin
      pend_data = next_word;
      next_word = next_word + 1'b1;
    end
  endtask

  // Asynchronous reset: outputs must clear at once, without waiting for a clock.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_fifo_pop", 32'(bus.fifo_pop), 32'd0);
    checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(bus.m_data), 32'd0);
    checkOutput("rst_occupancy", 32'(bus.occupancy), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    bus.fifo_empty = 1'b1;
    bus.m_ready    = 1'b0;
    bus.fifo_vld   = 1'b0;
    bus.fifo_data  = '0;
    sb.delete();
    pend_vld   = 1'b0;
    inflight_m = 1'b0;
    exp_err    = '0;
    next_word  = 24'd1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sb.size() != 0 || pend_vld); i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("drain_done", 32'(sb.size() == 0 && !pend_vld), 32'd1);
  endtask

  initial begin
    vec_t vecs[11];
    int   max_occ;
    int   first_beat;
    int   beats;

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 2, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 3, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 4, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 3, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 2, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 2, 1'b1};

    bus.fifo_empty = 1'b1;
    bus.m_ready    = 1'b0;
    bus.fifo_vld   = 1'b0;
    bus.fifo_data  = '0;
    #2;
    doReset();

    // Throughput of the DEPTH=2 and DEPTH=3 builds with the sink always ready.
    repeat (6) @(posedge clk);
    meas_on = 1'b1;
    repeat (30) @(posedge clk);
    meas_on = 1'b0;
    checkOutput("depth3_full_rate", 32'(beats3), 32'd30);
    checkOutput("depth2_reduced_rate", 32'(beats2 >= 15 && beats2 <= 20), 32'd1);
    $display("[TB] depth2 beats %0d, depth3 beats %0d in 30 cycles", beats2, beats3);

    // Streaming with the sink always ready.
    @(negedge clk);
    doReset();
    max_occ    = 0;
    first_beat = -1;
    beats      = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
      if (bus.m_valid) begin
        beats++;
        if (first_beat < 0) first_beat = c;
      end
    end
    checkOutput("first_beat_cycle", 32'(first_beat), 32'd2);
    checkOutput("stream_beats", 32'(beats), 32'd10);
    checkOutput("max_occ_le2", 32'(max_occ <= 2), 32'd1);
    drain();

    // Backpressure fill and release, table driven.
    @(negedge clk);
    doReset();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].empty, vecs[i].ready, 1'b0);
      checkOutput($sformatf("vec%0d_pop", i), 32'(bus.fifo_pop), 32'(vecs[i].exp_pop));
      checkOutput($sformatf("vec%0d_occ", i), 32'(bus.occupancy), 32'(vecs[i].exp_occ));
      checkOutput($sformatf("vec%0d_valid", i), 32'(bus.m_valid), 32'(vecs[i].exp_valid));
    end
    drain();

    // Toggling empty flag with random backpressure.
    @(negedge clk);
    doReset();
    for (int c = 0; c < 60; c++) begin
      applyStimulus(1'(c % 2), 1'($urandom_range(0, 1)), 1'b0);
    end
    drain();
    checkOutput("random_err_clean", 32'(bus.err), 32'd0);

    // Spurious return, then overflow into a full buffer.
    @(negedge clk);
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("spur_err", 32'(bus.err), 32'h2);
    checkOutput("spur_occ", 32'(bus.occupancy), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ovf_err", 32'(bus.err), 32'h3);
    checkOutput("ovf_occ", 32'(bus.occupancy), 32'd4);
    drain();

    // Reset while three words are held and a pop is in flight.
    @(negedge clk);
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_occ", 32'(bus.occupancy), 32'd3);
    checkOutput("pre_reset_err", 32'(bus.err), 32'h2);
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
